// File: rtl/net_output_stage.sv
// net_output_stage
//   Conditions the four network outputs for the pmod DAC once per sample.
//   Each channel is shifted back up to DAC scale with saturation, then scaled
//   by a shared fade gain g (0..G1, G1 = 2^RAMP_LOG2). A small FSM holds the
//   outputs silent during start-up warm-up and ramps g on mute/unmute.
//
// Ports
//   sample_clk  sample clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   in0..in3    signed W-bit network outputs
//   mute        level; 1 fades to silence, 0 fades back in
//   ch_en       per-channel enable; a disabled channel outputs 0, never clips
//   clip_clr    clears all sticky clip flags (a same-edge clip still sets)
//   out0..out3  registered conditioned samples
//   clip        registered sticky per-channel saturation flags
//   fsm_state   current state (WARMUP 0, RAMP_UP 1, RUN 2, RAMP_DOWN 3, MUTED 4)
module net_output_stage #(
  parameter int W         = 16,
  parameter int SHIFT     = 2,
  parameter int RAMP_LOG2 = 8,
  parameter int WARMUP    = 64
) (
  input  logic                sample_clk,
  input  logic                rst,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic                mute,
  input  logic [3:0]          ch_en,
  input  logic                clip_clr,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic [3:0]          clip,
  output logic [2:0]          fsm_state
);

  localparam int SW    = W + SHIFT;           // shifted sample width
  localparam int GW    = RAMP_LOG2 + 1;       // gain width, holds 0..G1
  localparam int PW    = W + RAMP_LOG2 + 1;   // product width
  localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [GW-1:0]    G1     = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0]    G1_M1  = {1'b0, {RAMP_LOG2{1'b1}}};
  localparam logic [GW-1:0]    G_ONE  = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WARMUP);
  // Exit compare value; with WARMUP = 0 the first edge already exits.
  localparam logic [CNT_W-1:0] CNT_EXIT = (WARMUP == 0) ? '0 : CNT_W'(WARMUP - 1);

  localparam logic signed [SW-1:0] S_MAX = {{(SHIFT+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(SHIFT+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_WARMUP    = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_MUTED     = 3'd4
  } state_t;

  state_t           state_reg;
  logic [GW-1:0]    g_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       clip_reg;
  logic [3:0]       clip_set;
  logic             out_live;
  logic [4*W-1:0]   out_flat;
  logic signed [W-1:0] in_arr [4];

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;

  // Gain/state sequencer. Direction reversals keep g for that edge so the
  // fade resumes from the current level without a step.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_WARMUP;
      g_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_WARMUP: begin
          g_reg <= '0;
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg >= CNT_EXIT) state_reg <= mute ? ST_MUTED : ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (mute) begin
            state_reg <= ST_RAMP_DOWN;
          end else if (g_reg >= G1_M1) begin
            g_reg     <= G1;
            state_reg <= ST_RUN;
          end else begin
            g_reg <= g_reg + G_ONE;
          end
        end
        ST_RUN: begin
          g_reg <= G1;
          if (mute) state_reg <= ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (!mute) begin
            state_reg <= ST_RAMP_UP;
          end else if (g_reg <= G_ONE) begin
            g_reg     <= '0;
            state_reg <= ST_MUTED;
          end else begin
            g_reg <= g_reg - G_ONE;
          end
        end
        ST_MUTED: begin
          g_reg <= '0;
          if (!mute) state_reg <= ST_RAMP_UP;
        end
        default: begin
          state_reg <= ST_WARMUP;
          g_reg     <= '0;
        end
      endcase
    end
  end

  assign fsm_state = state_reg;
  assign out_live  = (state_reg != ST_WARMUP) && (state_reg != ST_MUTED);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic signed [SW-1:0] s;
      logic                 ovf_hi;
      logic                 ovf_lo;
      logic signed [W-1:0]  sat;
      logic signed [PW-1:0] prod;
      logic                 prod_unused;
      logic signed [W-1:0]  out_reg;

      assign s      = SW'(in_arr[gi]) <<< SHIFT;
      assign ovf_hi = (s > S_MAX);
      assign ovf_lo = (s < S_MIN);
      assign sat    = ovf_hi ? {1'b0, {(W-1){1'b1}}} :
                      ovf_lo ? {1'b1, {(W-1){1'b0}}} : s[W-1:0];

      // g is unsigned; a zero MSB keeps it positive in the signed multiply.
      assign prod = PW'(sat) * $signed({{(PW-GW){1'b0}}, g_reg});
      // Taking bits above RAMP_LOG2 is the arithmetic (floor) shift; the
      // result always fits W bits because g never exceeds G1.
      assign prod_unused = ^{prod[PW-1], prod[RAMP_LOG2-1:0]};

      // Clip is judged before the gain so it reports even while silent.
      assign clip_set[gi] = ch_en[gi] & (ovf_hi | ovf_lo);

      always_ff @(posedge sample_clk or posedge rst) begin
        if (rst)                        out_reg <= '0;
        else if (ch_en[gi] && out_live) out_reg <= prod[RAMP_LOG2 +: W];
        else                            out_reg <= '0;
      end

      assign out_flat[gi*W +: W] = out_reg;
    end
  endgenerate

  // A new clip on the same edge as clip_clr survives the clear.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) clip_reg <= '0;
    else     clip_reg <= (clip_reg & {4{~clip_clr}}) | clip_set;
  end

  assign clip = clip_reg;
  assign out0 = out_flat[0*W +: W];
  assign out1 = out_flat[1*W +: W];
  assign out2 = out_flat[2*W +: W];
  assign out3 = out_flat[3*W +: W];

endmodule

// File: doc/net_output_stage.md
Name: net_output_stage

Overview:
- Post-processing stage directly downstream of the network forward pass. Consumes the four W-bit network outputs once per sample_clk and drives the eurorack pmod DAC channels.
- Per sample:
  - Restores pmod scaling with a saturating arithmetic left shift.
  - Applies a start-up warm-up mute while the activation caches fill.
  - Applies a linear fade gain on mute/unmute.
  - Reports sticky per-channel clip flags.

Parameters:
- W, 16: sample width, signed.
- SHIFT, 2: arithmetic left shift applied before saturation.
- RAMP_LOG2, 8: fade length is 2^RAMP_LOG2 samples; unity gain G1 = 2^RAMP_LOG2.
- WARMUP, 64: samples after reset during which outputs are forced to 0.

Ports:
- sample_clk  in  1  sample clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in0..in3  in  W each  signed network outputs, sampled on posedge sample_clk.
- mute  in  1  level; 1 requests fade to silence.
- ch_en  in  4  per-channel enable; bit i gates channel i.
- clip_clr  in  1  clears all clip flags.
- out0..out3  out  W each  signed conditioned samples, registered.
- clip  out  4  sticky saturation flags, registered.
- fsm_state  out  3  current state encoding (debug).

Behaviour:
- Reset (asynchronous, any time including mid-ramp):
  - out0..3 = 0, clip = 0.
  - State = WARMUP, warm-up counter = 0, gain g = 0.
- Latency: out at edge n uses in at edge n and the g value held before edge n. g and state update on the same edge.
- Per-channel arithmetic:
  - s = in <<< SHIFT, computed at W+SHIFT bits.
  - sat = clamp(s, -2^(W-1), 2^(W-1)-1).
  - y = (sat * g) >>> RAMP_LOG2, arithmetic shift (floor toward -inf). Product width is W+RAMP_LOG2+1.
  - With g = G1, y = sat exactly.
  - Channel with ch_en[i] = 0: out = 0 and clip[i] is not set.
- Clip:
  - clip[i] sets when ch_en[i] = 1 and s is outside the W-bit range. Evaluated pre-gain, so it also sets in WARMUP and MUTED.
  - clip_clr clears all bits.
  - Set and clear on the same edge: set wins.
- g is RAMP_LOG2+1 bits, range 0..G1.
- States:
  - WARMUP: outputs 0, counter += 1. On the edge where counter reaches WARMUP-1, go to MUTED if mute = 1, else RAMP_UP. g stays 0.
  - RAMP_UP: g += 1 per edge. When g becomes G1, go to RUN. mute = 1 goes to RAMP_DOWN on that edge without changing g.
  - RUN: g = G1. mute = 1 goes to RAMP_DOWN.
  - RAMP_DOWN: g -= 1 per edge. When g becomes 0, go to MUTED. mute = 0 goes to RAMP_UP on that edge without changing g.
  - MUTED: g = 0, outputs 0. mute = 0 goes to RAMP_UP.
- WARMUP = 0: first edge after reset behaves as a warm-up exit, going directly to RAMP_UP or MUTED.
- mute sampled during WARMUP affects only the exit target; the warm-up length is fixed.
- Warm-up counter width is clog2(WARMUP+1). It saturates; it does not wrap.
- fsm_state encoding: WARMUP = 0, RAMP_UP = 1, RUN = 2, RAMP_DOWN = 3, MUTED = 4.

Test Plan:
Common setup: W = 16, SHIFT = 2, RAMP_LOG2 = 2, WARMUP = 3, ch_en = 4'hF.
- Startup ramp: reset, in0 = 1000, mute = 0.
  - Edges 1-3: out0 = 0 (WARMUP).
  - Edges 4-8: out0 = 0, 1000, 2000, 3000, 4000; then 4000 steady.
  - fsm_state reaches 2 after edge 7.
- Saturation, in RUN:
  - in1 = 10000 -> out1 = 32767, clip = 4'b0010.
  - in1 = -9000 -> out1 = -32768, clip still set.
  - clip_clr together with in1 = 10000 -> clip stays 4'b0010.
  - clip_clr with in1 = 0 -> clip = 0.
- Negative floor: stop at g = 1 by toggling mute mid-ramp, in0 = -1 -> out0 = -1 (-4 * 1 >>> 2).
- Mute fade, in RUN, in0 = 1000:
  - Assert mute: outputs 4000, 3000, 2000, 1000, 0, then 0 with fsm_state = 4.
  - Deassert mute: outputs 0, 1000, 2000, 3000, 4000.
- Reversal and enable:
  - mute asserted at g = 2 during RAMP_UP -> next outputs use g = 2, 1, 0.
  - ch_en = 4'b1110 with in0 = 20000 -> out0 = 0, clip[0] = 0.
- Async reset mid-RAMP_DOWN: rst pulsed between clock edges -> outputs, clip and g are 0 immediately; the full 3-sample WARMUP repeats.
